// File: rtl/vga_frame_crc_if.sv
// Pixel bus from the ics32 video output: RGB444 pixel, data-enable and
// line/frame-end strobes. The video source is the master, the CRC sink the slave.
interface vga_frame_crc_if;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       vga_de;
    logic       line_ended;
    logic       frame_ended;

    modport master (output vga_r, vga_g, vga_b, vga_de, line_ended, frame_ended);
    modport slave  (input  vga_r, vga_g, vga_b, vga_de, line_ended, frame_ended);
endinterface

// File: rtl/vga_frame_crc.sv
// Per-frame CRC-32 and active-geometry checker sitting on the video output bus.
// Optional golden-CRC compare is built only with VGA_FRAME_CRC_GOLDEN_EN defined.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_SYNC    | wait for the first frame_ended; partial frame discarded
//   ST_CAPTURE | accumulate CRC / pixel / line counts, publish on frame_ended
module vga_frame_crc #(
    parameter int          H_ACTIVE   = 848,
    parameter int          V_ACTIVE   = 480,
    parameter logic [31:0] GOLDEN_CRC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    vga_frame_crc_if.slave        vid,
    output logic                  frame_valid,
    output logic [31:0]           frame_crc,
    output logic [9:0]            frame_lines,
    output logic                  geometry_error,
    output logic [15:0]           frame_count,
    output logic                  golden_mismatch
);

    localparam logic [0:0]  ST_SYNC    = 1'b0;
    localparam logic [0:0]  ST_CAPTURE = 1'b1;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;
    localparam logic [9:0]  H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  CNT_MAX    = 10'h3FF;

    // Twelve MSB-first bit steps unrolled into one cycle
    function automatic logic [31:0] crc_step12(input logic [31:0] crc, input logic [11:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 11; i >= 0; i--) begin
            if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
            else                 c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    logic [0:0]  state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [9:0]  pix_q, pix_d;
    logic [9:0]  line_q, line_d;
    logic        err_q, err_d;

    logic        valid_q, valid_d;
    logic [31:0] fcrc_q, fcrc_d;
    logic [9:0]  flines_q, flines_d;
    logic        ferr_q, ferr_d;
    logic [15:0] fcount_q, fcount_d;

    logic [11:0] pixel;
    logic [31:0] crc_px;
    logic [9:0]  pix_px;
    logic [9:0]  pix_cl;
    logic [9:0]  line_cl;
    logic        err_cl;

    assign pixel = {vid.vga_r, vid.vga_g, vid.vga_b};

    always_comb begin
        crc_px  = vid.vga_de ? crc_step12(crc_q, pixel) : crc_q;
        pix_px  = (vid.vga_de && pix_q != CNT_MAX) ? pix_q + 10'd1 : pix_q;
        pix_cl  = pix_px;
        line_cl = line_q;
        err_cl  = err_q;
        // A pixel coinciding with line_ended belongs to the line being closed
        if (vid.line_ended) begin
            pix_cl = 10'd0;
            if (pix_px != 10'd0) begin
                if (line_q != CNT_MAX) line_cl = line_q + 10'd1;
                if (pix_px != H_ACT)   err_cl  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        pix_d    = pix_q;
        line_d   = line_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        fcrc_d   = fcrc_q;
        flines_d = flines_q;
        ferr_d   = ferr_q;
        fcount_d = fcount_q;
        case (state_q)
            ST_SYNC: begin
                if (vid.frame_ended) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                crc_d  = crc_px;
                pix_d  = pix_cl;
                line_d = line_cl;
                err_d  = err_cl;
                if (vid.frame_ended) begin
                    valid_d  = 1'b1;
                    fcrc_d   = crc_px;
                    flines_d = line_cl;
                    ferr_d   = err_cl | (line_cl != V_ACT);
                    fcount_d = fcount_q + 16'd1;
                    crc_d    = CRC_INIT;
                    pix_d    = 10'd0;
                    line_d   = 10'd0;
                    err_d    = 1'b0;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_SYNC;
            crc_q    <= CRC_INIT;
            pix_q    <= 10'd0;
            line_q   <= 10'd0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            fcrc_q   <= 32'd0;
            flines_q <= 10'd0;
            ferr_q   <= 1'b0;
            fcount_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            pix_q    <= pix_d;
            line_q   <= line_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            fcrc_q   <= fcrc_d;
            flines_q <= flines_d;
            ferr_q   <= ferr_d;
            fcount_q <= fcount_d;
        end
    end

    assign frame_valid    = valid_q;
    assign frame_crc      = fcrc_q;
    assign frame_lines    = flines_q;
    assign geometry_error = ferr_q;
    assign frame_count    = fcount_q;

`ifdef VGA_FRAME_CRC_GOLDEN_EN
    logic golden_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            golden_q <= 1'b0;
        end else if (valid_q && fcrc_q != GOLDEN_CRC) begin
            golden_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && valid_q && fcrc_q != GOLDEN_CRC)
            $display("vga_frame_crc: golden crc differs, frame %0d crc %08h golden %08h",
                     fcount_q, fcrc_q, GOLDEN_CRC);
    end
`endif

    assign golden_mismatch = golden_q;
`else
    logic unused_golden;
    assign unused_golden   = ^GOLDEN_CRC;
    assign golden_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_vga_frame_crc.sv
// Directed bench for vga_frame_crc: a small 4x2 geometry instance for most
// scenarios plus a full-width 848-pixel instance over a short 3-line frame.
module tb_vga_frame_crc;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_frame_crc_if bus ();

    logic        s_valid, s_err, s_gold;
    logic [31:0] s_crc;
    logic [9:0]  s_lines;
    logic [15:0] s_count;
    logic        w_valid, w_err, w_gold;
    logic [31:0] w_crc;
    logic [9:0]  w_lines;
    logic [15:0] w_count;

    vga_frame_crc #(.H_ACTIVE(4), .V_ACTIVE(2), .GOLDEN_CRC(32'hFFFF_FFFF)) ds (
        .clk(clk), .reset(reset), .vid(bus),
        .frame_valid(s_valid), .frame_crc(s_crc), .frame_lines(s_lines),
        .geometry_error(s_err), .frame_count(s_count), .golden_mismatch(s_gold));

    vga_frame_crc #(.H_ACTIVE(848), .V_ACTIVE(3)) dw (
        .clk(clk), .reset(reset), .vid(bus),
        .frame_valid(w_valid), .frame_crc(w_crc), .frame_lines(w_lines),
        .geometry_error(w_err), .frame_count(w_count), .golden_mismatch(w_gold));

    int checks = 0;
    int errors = 0;
    int vcnt_s = 0;
    int vcnt_w = 0;
    logic [31:0] exp_crc;
    logic [11:0] pat [4] = '{12'h123, 12'h456, 12'h789, 12'hABC};

    always @(posedge clk) begin
        if (s_valid) vcnt_s <= vcnt_s + 1;
        if (w_valid) vcnt_w <= vcnt_w + 1;
    end

    // Reference CRC-32: poly 04C11DB7, MSB-first, no reflection, no final xor
    function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [11:0] w);
        logic [31:0] r;
        logic        msb;
        r = c;
        for (int b = 11; b >= 0; b--) begin
            msb = r[31];
            r   = r << 1;
            if (msb != w[b]) r = r ^ 32'h04C1_1DB7;
        end
        return r;
    endfunction

    task automatic cyc(input logic de, input logic [11:0] px, input logic le, input logic fe);
        bus.vga_de      = de;
        bus.vga_r       = px[11:8];
        bus.vga_g       = px[7:4];
        bus.vga_b       = px[3:0];
        bus.line_ended  = le;
        bus.frame_ended = fe;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(0, 12'h000, 0, 0);
        cyc(0, 12'h000, 0, 0);
        reset = 1'b0;
    endtask

    // Two lines on the 4x2 instance; first line may be short. Ends on the fe edge.
    task automatic send_frame_small(input int n_first);
        int n;
        exp_crc = 32'hFFFF_FFFF;
        for (int ln = 0; ln < 2; ln++) begin
            n = (ln == 0) ? n_first : 4;
            for (int k = 0; k < n; k++) begin
                cyc(1, pat[k], 0, 0);
                exp_crc = model_crc(exp_crc, pat[k]);
            end
            cyc(0, 12'h000, 1, (ln == 1));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(0, 12'h000, 0, 0);
        cyc(0, 12'h000, 0, 0);
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", s_valid); end
        checks++; if (s_crc !== 32'd0) begin errors++; $display("FAIL reset_crc got %h want 0", s_crc); end
        checks++; if (s_lines !== 10'd0) begin errors++; $display("FAIL reset_lines got %0d want 0", s_lines); end
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", s_err); end
        checks++; if (s_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", s_count); end
        checks++; if (s_gold !== 1'b0) begin errors++; $display("FAIL reset_golden got %b want 0", s_gold); end
        reset = 1'b0;
    endtask

    task automatic test_good_frames();
        int v0;
        logic [31:0] first_crc;
        do_reset();
        cyc(0, 12'h000, 0, 1);
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL leadin_valid got %b want 0", s_valid); end
        send_frame_small(4);
        first_crc = exp_crc;
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL good_valid got %b want 1", s_valid); end
        checks++; if (s_lines !== 10'd2) begin errors++; $display("FAIL good_lines got %0d want 2", s_lines); end
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL good_err got %b want 0", s_err); end
        checks++; if (s_crc !== exp_crc) begin errors++; $display("FAIL good_crc got %h want %h", s_crc, exp_crc); end
        checks++; if (s_count !== 16'd1) begin errors++; $display("FAIL good_count got %0d want 1", s_count); end
        v0 = vcnt_s;
        cyc(0, 12'h000, 0, 0);
        cyc(0, 12'h000, 0, 0);
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse got %b want 0", s_valid); end
        checks++; if (vcnt_s !== v0 + 1) begin errors++; $display("FAIL valid_width got %0d want %0d", vcnt_s, v0 + 1); end
        checks++; if (s_crc !== first_crc) begin errors++; $display("FAIL hold_crc got %h want %h", s_crc, first_crc); end
        send_frame_small(4);
        checks++; if (s_crc !== first_crc) begin errors++; $display("FAIL repeat_crc got %h want %h", s_crc, first_crc); end
        checks++; if (s_count !== 16'd2) begin errors++; $display("FAIL repeat_count got %0d want 2", s_count); end
    endtask

    task automatic test_bad_width();
        send_frame_small(3);
        checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL short_err got %b want 1", s_err); end
        checks++; if (s_lines !== 10'd2) begin errors++; $display("FAIL short_lines got %0d want 2", s_lines); end
        checks++; if (s_crc !== exp_crc) begin errors++; $display("FAIL short_crc got %h want %h", s_crc, exp_crc); end
        send_frame_small(4);
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL recover_err got %b want 0", s_err); end
    endtask

    task automatic test_sync_discard();
        int v0;
        do_reset();
        v0 = vcnt_s;
        for (int k = 0; k < 4; k++) cyc(1, pat[k], 0, 0);
        cyc(0, 12'h000, 1, 1);
        cyc(0, 12'h000, 0, 0);
        checks++; if (vcnt_s !== v0) begin errors++; $display("FAIL sync_valid got %0d pulses want 0", vcnt_s - v0); end
        checks++; if (s_count !== 16'd0) begin errors++; $display("FAIL sync_count got %0d want 0", s_count); end
        send_frame_small(4);
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL sync_second_valid got %b want 1", s_valid); end
        checks++; if (s_count !== 16'd1) begin errors++; $display("FAIL sync_second_count got %0d want 1", s_count); end
    endtask

    task automatic test_simultaneous();
        int v0;
        do_reset();
        cyc(0, 12'h000, 0, 1);
        exp_crc = 32'hFFFF_FFFF;
        for (int ln = 0; ln < 2; ln++) begin
            for (int k = 0; k < 4; k++) begin
                cyc(1, pat[k], (k == 3), (k == 3 && ln == 1));
                exp_crc = model_crc(exp_crc, pat[k]);
            end
        end
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL simul_valid got %b want 1", s_valid); end
        checks++; if (s_lines !== 10'd2) begin errors++; $display("FAIL simul_lines got %0d want 2", s_lines); end
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL simul_err got %b want 0", s_err); end
        checks++; if (s_crc !== exp_crc) begin errors++; $display("FAIL simul_crc got %h want %h", s_crc, exp_crc); end
        cyc(1, pat[0], 0, 0);
        cyc(1, pat[1], 0, 0);
        reset = 1'b1;
        cyc(1, pat[2], 0, 0);
        checks++; if (s_crc !== 32'd0) begin errors++; $display("FAIL midreset_crc got %h want 0", s_crc); end
        checks++; if (s_count !== 16'd0) begin errors++; $display("FAIL midreset_count got %0d want 0", s_count); end
        checks++; if (s_lines !== 10'd0) begin errors++; $display("FAIL midreset_lines got %0d want 0", s_lines); end
        reset = 1'b0;
        v0 = vcnt_s;
        cyc(1, pat[3], 1, 0);
        cyc(0, 12'h000, 1, 1);
        cyc(0, 12'h000, 0, 0);
        checks++; if (vcnt_s !== v0) begin errors++; $display("FAIL midreset_discard got %0d pulses want 0", vcnt_s - v0); end
    endtask

    task automatic test_empty_frame();
        cyc(0, 12'h000, 0, 1);
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL empty_valid got %b want 1", s_valid); end
        checks++; if (s_crc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL empty_crc got %h want ffffffff", s_crc); end
        checks++; if (s_lines !== 10'd0) begin errors++; $display("FAIL empty_lines got %0d want 0", s_lines); end
        checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL empty_err got %b want 1", s_err); end
    endtask

    task automatic test_wide();
        int v0;
        do_reset();
        cyc(0, 12'h000, 0, 1);
        v0 = vcnt_w;
        exp_crc = 32'hFFFF_FFFF;
        for (int ln = 0; ln < 3; ln++) begin
            for (int k = 0; k < 848; k++) begin
                cyc(1, 12'h000, (k == 847), (k == 847 && ln == 2));
                exp_crc = model_crc(exp_crc, 12'h000);
            end
        end
        cyc(0, 12'h000, 0, 0);
        checks++; if (vcnt_w !== v0 + 1) begin errors++; $display("FAIL wide_valid got %0d pulses want 1", vcnt_w - v0); end
        checks++; if (w_lines !== 10'd3) begin errors++; $display("FAIL wide_lines got %0d want 3", w_lines); end
        checks++; if (w_err !== 1'b0) begin errors++; $display("FAIL wide_err got %b want 0", w_err); end
        checks++; if (w_count !== 16'd1) begin errors++; $display("FAIL wide_count got %0d want 1", w_count); end
        checks++; if (w_crc !== exp_crc) begin errors++; $display("FAIL wide_crc got %h want %h", w_crc, exp_crc); end
        checks++; if (w_gold !== 1'b0) begin errors++; $display("FAIL wide_golden got %b want 0", w_gold); end
    endtask

    task automatic test_golden();
        do_reset();
        cyc(0, 12'h000, 0, 1);
        send_frame_small(4);
        cyc(0, 12'h000, 0, 0);
`ifdef VGA_FRAME_CRC_GOLDEN_EN
        checks++; if (s_gold !== 1'b1) begin errors++; $display("FAIL golden_set got %b want 1", s_gold); end
`else
        checks++; if (s_gold !== 1'b0) begin errors++; $display("FAIL golden_tied got %b want 0", s_gold); end
`endif
        test_empty_frame();
        cyc(0, 12'h000, 0, 0);
`ifdef VGA_FRAME_CRC_GOLDEN_EN
        checks++; if (s_gold !== 1'b1) begin errors++; $display("FAIL golden_sticky got %b want 1", s_gold); end
`else
        checks++; if (s_gold !== 1'b0) begin errors++; $display("FAIL golden_tied2 got %b want 0", s_gold); end
`endif
        do_reset();
        checks++; if (s_gold !== 1'b0) begin errors++; $display("FAIL golden_clear got %b want 0", s_gold); end
    endtask

    initial begin
        bus.vga_de = 1'b0; bus.vga_r = 4'h0; bus.vga_g = 4'h0; bus.vga_b = 4'h0;
        bus.line_ended = 1'b0; bus.frame_ended = 1'b0;
        test_reset();
        test_good_frames();
        test_bad_width();
        test_sync_discard();
        test_simultaneous();
        test_wide();
        test_golden();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_frame_crc.md
Name: vga_frame_crc

Overview:
- Simulation/regression sink directly downstream of the ics32 video output.
- Consumes the pixel bus, data-enable and line/frame-end strobes.
- Per frame, computes a CRC-32 over all active pixels and checks active geometry; publishes one result per frame.
- Lets benches compare rendered frames against golden values without dumping images.

Parameters:
- H_ACTIVE, 848, required active pixels per line (widescreen mode).
- V_ACTIVE, 480, required active lines per frame.
- GOLDEN_CRC, 32'h0000_0000, expected frame CRC; used only with the optional feature.

Ports:
- clk  input  1  pixel clock (driven from vga_clk); all logic on rising edge.
- reset  input  1  synchronous, active-high.
- vga_r  input  4  red.
- vga_g  input  4  green.
- vga_b  input  4  blue.
- vga_de  input  1  active-pixel qualifier.
- line_ended  input  1  one-cycle strobe, last cycle of a line.
- frame_ended  input  1  one-cycle strobe, last cycle of a frame.
- frame_valid  output  1  one-cycle pulse when frame results update.
- frame_crc  output  32  CRC of last completed frame.
- frame_lines  output  10  active lines counted in last frame.
- geometry_error  output  1  last frame had a bad line width or line count.
- frame_count  output  16  completed frames since reset; wraps 16'hFFFF -> 0.
- golden_mismatch  output  1  sticky; see Optional Feature.

Behaviour:
- Reset (sync, active-high): all outputs 0; state = SYNC; accumulators cleared.
- State SYNC: ignore all input until frame_ended. On frame_ended go to CAPTURE with clean accumulators. No frame_valid is issued, so the first partial frame is discarded.
- State CAPTURE:
  - Each cycle with vga_de=1, pixel word {r,g,b} (12 bits, r[3] first) is shifted MSB-first into CRC-32.
  - CRC: poly 0x04C11DB7, non-reflected, init 0xFFFFFFFF, no final XOR. All 12 bit-steps complete in one cycle.
  - Pixel counter (10 bits, saturating at 1023) increments per de cycle.
  - line_ended:
    - If the pixel count is non-zero, it is compared with H_ACTIVE; mismatch sets the internal error bit.
    - The line counter (10 bits, saturating) increments only if at least one de pixel occurred in that line.
    - The pixel counter then clears.
  - frame_ended:
    - Registers the outputs on the next edge: frame_crc, frame_lines, geometry_error = error | (lines != V_ACTIVE).
    - frame_valid pulses 1 cycle (latency 1 cycle after the frame_ended strobe).
    - frame_count increments.
    - Accumulators reinitialise.
- Simultaneous events:
  - de with line_ended: that pixel counts toward the ending line and its CRC.
  - de with frame_ended: that pixel is included in the closing frame.
  - line_ended with frame_ended: the line is closed first, then the frame.
  - A de pixel after line_ended but with no new line start belongs to the next line.
- No flow control: the block accepts every cycle and never stalls upstream.
- Outputs hold between frame_valid pulses.
- Reset mid-frame: partial data is discarded, the block returns to SYNC, and outputs clear.
- Non-de cycles do not alter the CRC.
- A frame with zero active pixels reports CRC 0xFFFFFFFF with lines = 0, and geometry_error = 1 when V_ACTIVE != 0.

Optional Feature:
- Macro: VGA_FRAME_CRC_GOLDEN_EN.
- With it defined: on each frame_valid, if the registered CRC != GOLDEN_CRC, golden_mismatch sets and stays set until reset. A simulation $display reports frame_count and both CRC values.
- Without it: golden_mismatch is tied 0, GOLDEN_CRC is unused, and no compare logic is built.

Test Plan:
- Reset then a full 848x480 frame of pixel 12'h000 preceded by a lead-in frame_ended -> exactly one frame_valid; frame_lines=480; geometry_error=0; frame_count=1; frame_crc equals the bench software model over 407040 zero words.
- Override H_ACTIVE=4, V_ACTIVE=2; pixels 12'h123, 12'h456, 12'h789, 12'hABC per line -> frame_lines=2, geometry_error=0, CRC matches the software model. Repeat the frame: identical CRC, frame_count=2.
- Same override, one line with 3 de pixels -> geometry_error=1 for that frame only; the next good frame reports 0.
- No lead-in strobe: pixels then the first frame_ended -> no frame_valid (SYNC discard). The second frame_ended produces the first frame_valid.
- de pixel asserted in the same cycle as line_ended and frame_ended -> that pixel is counted in the closing line and frame. Then reset asserted mid-line -> all outputs 0 next cycle and the next frame_ended is discarded.
- With VGA_FRAME_CRC_GOLDEN_EN and GOLDEN_CRC set to a wrong value -> golden_mismatch=1 after the first frame_valid and stays 1 after a subsequent matching frame; cleared only by reset.
